retire_trace_unit: RTL and testbench
====================================

Name: retire_trace_unit

Overview:
- Sits at the CPU writeback stage and turns every retired instruction into a trace record: sequence number, pc, instruction, rd, write-enable and write data.
- Records are buffered in a FIFO and offered to a checker/monitor over a valid/ready stream.
- This is the producer side of the writeback-comparison path: the checker no longer reconstructs pipeline timing, it consumes records in retire order.
- Handles CPU halt by draining the buffer, then signalling done.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- SEQ_W, 16, retire sequence counter width.
- DROP_W, 16, dropped-record counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc  in  32  pc of the retiring instruction.
- wb_instr  in  32  instruction word.
- wb_rd  in  5  destination register.
- wb_we  in  1  register-file write enable.
- wb_data  in  32  writeback data.
- halt_i  in  1  CPU halt (ohalt).
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts the head record.
- trace_rec  out  SEQ_W+102  head record {seq, pc, instr, rd, we, data}.
- overflow  out  1  sticky: at least one record was dropped.
- drop_cnt  out  DROP_W  dropped-record count, saturating.
- trace_done  out  1  halt seen and FIFO fully drained.
- cpu_stall_o  out  1  backpressure request to the CPU (see Optional Feature).

Behaviour:
- Reset (synchronous, next rising edge with rst=1):
  - FIFO empty; trace_valid=0; trace_rec=0.
  - seq=0; overflow=0; drop_cnt=0; trace_done=0; cpu_stall_o=0; state=RUN.
  - Any in-flight records are lost.
- State machine:
  - RUN -> DRAIN on halt_i=1.
  - DRAIN -> DONE when the FIFO is empty at the clock edge. This includes the first DRAIN cycle if the FIFO is already empty.
  - DONE holds until rst.
  - trace_done=1 in DONE only.
- Capture (RUN only):
  - On wb_valid=1, build a record with the current seq; seq increments and wraps 2^SEQ_W-1 -> 0.
  - If wb_we=1 and wb_rd=0, store we=0 and data=0 (x0 is never written).
  - If wb_we=0, store data=0.
  - On the cycle halt_i rises, a coincident wb_valid is still captured.
  - In DRAIN and DONE, wb_valid is ignored: no capture, no seq increment, no drop count.
- Latency: a record captured at edge N is visible on trace_valid/trace_rec after edge N (one cycle). FIFO output is first-word-fall-through.
- Push/pop rules:
  - Pop occurs when trace_valid & trace_ready.
  - Push occurs if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Simultaneous push and pop on an empty FIFO: the push lands and the FIFO is not bypassed; trace_valid asserts next cycle.
  - Full with no pop: the record is dropped, overflow sets (sticky) and drop_cnt increments, saturating at 2^DROP_W-1. seq still increments, so the consumer sees the gap.
- Stream rules:
  - trace_rec is stable while trace_valid=1 and trace_ready=0.
  - trace_valid never deasserts without a pop.
- Pointers and count:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - A count of log2(DEPTH)+1 bits distinguishes full from empty.
- cpu_stall_o is 0 unless TRACE_BACKPRESSURE_EN is defined.

Optional Feature:
- Macro: TRACE_BACKPRESSURE_EN.
- Defined:
  - cpu_stall_o = registered (count >= DEPTH-1 or (count == DEPTH-2 and push and not pop)). It is high whenever the FIFO will hold at least DEPTH-1 entries after the edge.
  - The CPU must not retire while it is high, so a compliant CPU causes zero drops.
  - Overflow logic is retained and still counts violations.
- Undefined:
  - cpu_stall_o is tied to 0.
  - Drops are possible.

Decomposition:
- Package riscv_trace_pkg holds:
  - typedef retire_rec_t, a packed struct {seq, pc, instr, rd, we, data};
  - enum trace_state_t {RUN, DRAIN, DONE};
  - localparam X0 = 5'd0.
- SEQ_W is fixed at 16 inside the package struct.
- One sub-module, trace_fifo: parameterised width/depth, synchronous FWFT FIFO with full/empty/count outputs.

Test Plan:
- Reset, then 3 retires: ADDI x1 (data 0x5), LW x2 (data 0xDEADBEEF), store with we=0; trace_ready=1 -> records with seq 0, 1, 2 appear one cycle after each capture; the store record has data=0.
- Retire with wb_we=1, wb_rd=0, wb_data=0x1234 -> record has we=0, data=0.
- trace_ready=0, DEPTH=8, 10 retires -> 8 records buffered, overflow=1, drop_cnt=2. Release ready -> seq 0..7 delivered in order. Next retire gets seq 10.
- FIFO full, simultaneous push and pop -> no drop, count stays 8, overflow stays 0.
- 3 buffered records, halt_i pulsed with coincident wb_valid, ready held low 5 cycles, then high -> 4 records delivered; retires after halt ignored; trace_done=1 the cycle after the FIFO empties.
- rst asserted mid-DRAIN with 2 records buffered -> next cycle trace_valid=0, trace_done=0, seq=0, state=RUN. With TRACE_BACKPRESSURE_EN, ready=0 -> cpu_stall_o=1 once count reaches 7, drop_cnt stays 0.

Source files
------------

// File: rtl/riscv_trace_pkg.sv
// Shared types for the retire trace path: the trace record layout,
// the drain state machine encoding and the x0 register index.
package riscv_trace_pkg;

  localparam logic [4:0] X0 = 5'd0;

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } retire_rec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count.
// A push while full is accepted only when a pop happens in the same cycle.
// An empty FIFO presents all-zero data.
module trace_fifo #(
  parameter int unsigned WIDTH = 118,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/retire_trace_unit.sv
// Writeback-stage retire tracer: captures each retired instruction as a
// sequenced record, buffers it in a FWFT FIFO and streams it out over
// valid/ready. On CPU halt the buffer drains and trace_done asserts.
// Optional macro TRACE_BACKPRESSURE_EN enables the cpu_stall_o request.
module retire_trace_unit
  import riscv_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SEQ_W  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_instr,
  input  logic [4:0]           wb_rd,
  input  logic                 wb_we,
  input  logic [31:0]          wb_data,
  input  logic                 halt_i,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [SEQ_W+101:0]   trace_rec,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 trace_done,
  output logic                 cpu_stall_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_state_t       state_q;
  trace_state_t       state_d;
  logic [SEQ_W-1:0]   seq_q;
  retire_rec_t        rec_in;
  logic               capture;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               rec_we;

  assign capture = wb_valid && (state_q == RUN);
  assign pop     = trace_valid && trace_ready;
  assign push_ok = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  // x0 is never written, so its write enable and data are squashed.
  assign rec_we        = wb_we && (wb_rd != X0);
  assign rec_in.seq    = seq_q;
  assign rec_in.pc     = wb_pc;
  assign rec_in.instr  = wb_instr;
  assign rec_in.rd     = wb_rd;
  assign rec_in.we     = rec_we;
  assign rec_in.data   = rec_we ? wb_data : '0;

  trace_fifo #(
    .WIDTH ($bits(retire_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (rec_in),
    .pop   (pop),
    .dout  (trace_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign trace_valid = !fifo_empty;

  // State register for the run/drain/done sequence.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state and done flag; DRAIN completes on an empty FIFO at the edge.
  always_comb begin
    state_d    = state_q;
    trace_done = 1'b0;
    case (state_q)
      RUN:     if (halt_i) state_d = DRAIN;
      DRAIN:   if (fifo_count == '0) state_d = DONE;
      DONE:    trace_done = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Sequence counter advances on every capture, dropped or not.
  always_ff @(posedge clk) begin
    if (rst)          seq_q <= '0;
    else if (capture) seq_q <= seq_q + 1'b1;
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef TRACE_BACKPRESSURE_EN
  logic stall_q;

  // Stall request whenever the FIFO will hold at least DEPTH-1 entries.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= 1'b0;
    else     stall_q <= (fifo_count >= (AW+1)'(DEPTH - 1)) ||
                        ((fifo_count == (AW+1)'(DEPTH - 2)) && push_ok && !pop);
  end

  assign cpu_stall_o = stall_q;
`else
  assign cpu_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed self-checking bench for retire_trace_unit (DEPTH=8, SEQ_W=16).
module tb_retire_trace_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid;
  logic [31:0]  wb_pc;
  logic [31:0]  wb_instr;
  logic [4:0]   wb_rd;
  logic         wb_we;
  logic [31:0]  wb_data;
  logic         halt_i;
  logic         trace_valid;
  logic         trace_ready;
  logic [117:0] trace_rec;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic         trace_done;
  logic         cpu_stall_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic        exp_stall_full;

  retire_trace_unit #(
    .DEPTH  (8),
    .SEQ_W  (16),
    .DROP_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_pc       (wb_pc),
    .wb_instr    (wb_instr),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_data     (wb_data),
    .halt_i      (halt_i),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_rec   (trace_rec),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .trace_done  (trace_done),
    .cpu_stall_o (cpu_stall_o)
  );

  always #5 clk = ~clk;

  function automatic logic [117:0] rec(input logic [15:0] seq, input logic [31:0] pc,
                                       input logic [31:0] instr, input logic [4:0] rd,
                                       input logic we, input logic [31:0] data);
    return {seq, pc, instr, rd, we, data};
  endfunction

  // Record expected for the i-th retire of the generic pattern (all we=1, rd!=0).
  function automatic logic [117:0] pat(input int unsigned s, input int unsigned i);
    return rec(16'(s), 32'h200 + 32'(4*i), 32'(i), 5'(i+1), 1'b1, 32'(i) * 32'h11);
  endfunction

  task automatic chk(input string tag, input logic [117:0] obs, input logic [117:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] rd, input logic we, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = instr;
    wb_rd    = rd;
    wb_we    = we;
    wb_data  = data;
    tick();
  endtask

  task automatic drive_pat(input int unsigned i);
    drive(32'h200 + 32'(4*i), 32'(i), 5'(i+1), 1'b1, 32'(i) * 32'h11);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wb_valid = 1'b0;
    halt_i   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
`ifdef TRACE_BACKPRESSURE_EN
    exp_stall_full = 1'b1;
`else
    exp_stall_full = 1'b0;
`endif
    trace_ready = 1'b0;
    wb_pc = '0; wb_instr = '0; wb_rd = '0; wb_we = 1'b0; wb_data = '0;
    do_reset();
    chk("rst_valid", 118'(trace_valid), 118'(0));
    chk("rst_rec", trace_rec, 118'(0));
    chk("rst_ovf", 118'(overflow), 118'(0));
    chk("rst_drop", 118'(drop_cnt), 118'(0));
    chk("rst_done", 118'(trace_done), 118'(0));
    chk("rst_stall", 118'(cpu_stall_o), 118'(0));

    // Three retires streamed straight through, then an x0 write.
    trace_ready = 1'b1;
    drive(32'h100, 32'h00500093, 5'd1, 1'b1, 32'h5);
    chk("addi_valid", 118'(trace_valid), 118'(1));
    chk("addi_rec", trace_rec, rec(16'd0, 32'h100, 32'h00500093, 5'd1, 1'b1, 32'h5));
    drive(32'h104, 32'h0000A103, 5'd2, 1'b1, 32'hDEADBEEF);
    chk("lw_rec", trace_rec, rec(16'd1, 32'h104, 32'h0000A103, 5'd2, 1'b1, 32'hDEADBEEF));
    drive(32'h108, 32'h0020A223, 5'd4, 1'b0, 32'h55);
    chk("sw_rec", trace_rec, rec(16'd2, 32'h108, 32'h0020A223, 5'd4, 1'b0, 32'h0));
    drive(32'h10C, 32'h00000013, 5'd0, 1'b1, 32'h1234);
    chk("x0_rec", trace_rec, rec(16'd3, 32'h10C, 32'h00000013, 5'd0, 1'b0, 32'h0));
    wb_valid = 1'b0;
    tick();
    chk("drained_valid", 118'(trace_valid), 118'(0));

    // Overflow: ten retires into an eight-deep FIFO with no consumer.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_pat(i);
      if (i == 7) chk("full_no_ovf", 118'(overflow), 118'(0));
    end
    chk("ovf_set", 118'(overflow), 118'(1));
    chk("ovf_drop2", 118'(drop_cnt), 118'(2));
    wb_valid    = 1'b0;
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", trace_rec, pat(i, i));
      tick();
    end
    chk("ovf_empty", 118'(trace_valid), 118'(0));
    drive(32'h300, 32'h13, 5'd3, 1'b1, 32'h77);
    chk("seq_gap", trace_rec, rec(16'd10, 32'h300, 32'h13, 5'd3, 1'b1, 32'h77));
    wb_valid = 1'b0;
    tick();

    // Full FIFO with simultaneous push and pop: nothing is dropped.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_pat(i);
    chk("full8_ovf", 118'(overflow), 118'(0));
    trace_ready = 1'b1;
    drive_pat(8);
    wb_valid = 1'b0;
    chk("pp_ovf", 118'(overflow), 118'(0));
    chk("pp_drop", 118'(drop_cnt), 118'(0));
    for (int i = 1; i <= 8; i++) begin
      chk("pp_order", trace_rec, pat(i, i));
      tick();
    end
    chk("pp_empty", 118'(trace_valid), 118'(0));

    // Halt with a coincident retire, later retires ignored, drain to done.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_pat(i);
    halt_i = 1'b1;
    drive_pat(3);
    halt_i = 1'b0;
    wb_pc  = 32'h999;
    for (int i = 0; i < 5; i++) tick();
    chk("halt_notdone", 118'(trace_done), 118'(0));
    chk("halt_drop", 118'(drop_cnt), 118'(0));
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", trace_rec, pat(i, i));
      tick();
    end
    chk("drain_empty", 118'(trace_valid), 118'(0));
    chk("drain_notyet", 118'(trace_done), 118'(0));
    tick();
    chk("done_set", 118'(trace_done), 118'(1));
    chk("done_novalid", 118'(trace_valid), 118'(0));
    tick();
    chk("done_hold", 118'(trace_done), 118'(1));
    wb_valid = 1'b0;

    // Reset in the middle of a drain.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 2; i++) drive_pat(i);
    wb_valid = 1'b0;
    halt_i   = 1'b1;
    tick();
    halt_i = 1'b0;
    tick();
    chk("middrain_valid", 118'(trace_valid), 118'(1));
    chk("middrain_done", 118'(trace_done), 118'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 118'(trace_valid), 118'(0));
    chk("mrst_done", 118'(trace_done), 118'(0));
    chk("mrst_rec", trace_rec, 118'(0));
    trace_ready = 1'b1;
    drive_pat(5);
    chk("mrst_seq0", trace_rec, pat(0, 5));
    wb_valid = 1'b0;
    tick();
    chk("mrst_run_done", 118'(trace_done), 118'(0));

    // Stall request as the FIFO approaches full.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_pat(i);
      if (i == 5) chk("stall_at6", 118'(cpu_stall_o), 118'(0));
    end
    chk("stall_at7", 118'(cpu_stall_o), 118'(exp_stall_full));
    chk("stall_drop", 118'(drop_cnt), 118'(0));
    wb_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
